// File: rtl/gray_to_binary_code.sv
`default_nettype none
// ============================================================================
//  Module      : gray_to_binary_code
//  Description : Registered reflected-binary Gray to binary converter with
//                a one-bit-neighbour (adjacency) checker on the accepted
//                word stream. One word per cycle, no backpressure.
//  Revision    : 1.0  initial release
// ============================================================================
module gray_to_binary_code #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] G,
    output logic [WIDTH-1:0] bin,
    output logic             out_valid,
    output logic             adj_err
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_diff;
    logic             w_one_bit;

    logic [WIDTH-1:0] r_bin;
    logic             r_out_valid;
    logic             r_adj_err;
    logic [WIDTH-1:0] r_prev_g;
    logic             r_have_prev;

    // Each binary bit is the XOR of all Gray bits at or above its position;
    // expressing it per bit keeps the logic free of a self-referencing chain.
    for (genvar i = 0; i < WIDTH; i++) begin : g_conv
        assign w_bin[i] = ^G[WIDTH-1:i];
    end

    // Adjacent words differ in exactly one bit: the difference is nonzero
    // and clearing its lowest set bit leaves nothing behind.
    always_comb begin
        w_diff    = G ^ r_prev_g;
        w_one_bit = (w_diff != '0) && ((w_diff & (w_diff - c_ONE)) == '0);
    end

    // Accepted words update result, history and the adjacency flag; an idle
    // cycle only drops out_valid so G is never observed when in_valid is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin       <= '0;
            r_out_valid <= 1'b0;
            r_adj_err   <= 1'b0;
            r_prev_g    <= '0;
            r_have_prev <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_bin       <= w_bin;
                r_prev_g    <= G;
                r_have_prev <= 1'b1;
                r_adj_err   <= r_have_prev ? !w_one_bit : 1'b0;
            end
        end
    end

    assign bin       = r_bin;
    assign out_valid = r_out_valid;
    assign adj_err   = r_adj_err;

endmodule
`default_nettype wire

// File: tb/tb_gray_to_binary_code.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_to_binary_code
//  Description : Directed self-checking bench for gray_to_binary_code,
//                4-bit instance for the stream scenarios plus an 8-bit
//                instance for the exhaustive conversion sweep.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gray_to_binary_code;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] g4;
    logic [7:0] g8;
    logic [3:0] bin4;
    logic [7:0] bin8;
    logic       ov4, ov8, ae4, ae8;

    int n_checks;
    int n_errors;

    gray_to_binary_code #(.WIDTH(4)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .G        (g4),
        .bin      (bin4),
        .out_valid(ov4),
        .adj_err  (ae4)
    );

    gray_to_binary_code #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .G        (g8),
        .bin      (bin8),
        .out_valid(ov8),
        .adj_err  (ae8)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs at a falling edge, then advance to the next falling edge
    // so outputs reflect the rising edge that consumed them.
    task automatic step(input logic rn, input logic v, input logic [3:0] g);
        rst_n    = rn;
        in_valid = v;
        g4       = g;
        @(negedge clk);
    endtask

    function automatic logic [7:0] g2b8(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int k = 6; k >= 0; k--) b[k] = b[k+1] ^ g[k];
        return b;
    endfunction

    logic [3:0] seq [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                             4'b0110, 4'b0111, 4'b0101, 4'b0100,
                             4'b1100, 4'b1101, 4'b1111, 4'b1110,
                             4'b1010, 4'b1011, 4'b1001, 4'b1000};

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        g4       = '0;
        g8       = '0;
        @(negedge clk);

        // Reset state, with a word presented during reset
        step(1'b0, 1'b1, 4'b1011);
        check("rst_bin", 32'(bin4), 32'h0);
        check("rst_ov",  32'(ov4),  32'h0);
        check("rst_ae",  32'(ae4),  32'h0);

        // Full Gray sequence, back to back
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, seq[i]);
            check($sformatf("seq_bin%0d", i), 32'(bin4), 32'(i));
            check($sformatf("seq_ov%0d", i),  32'(ov4),  32'h1);
            check($sformatf("seq_ae%0d", i),  32'(ae4),  32'h0);
        end

        // Wrap-around 1000 -> 0000
        step(1'b1, 1'b1, 4'b0000);
        check("wrap_bin", 32'(bin4), 32'h0);
        check("wrap_ae",  32'(ae4),  32'h0);

        // Non-adjacent step
        step(1'b1, 1'b1, 4'b0001);
        check("na0_bin", 32'(bin4), 32'h1);
        check("na0_ae",  32'(ae4),  32'h0);
        step(1'b1, 1'b1, 4'b0111);
        check("na1_bin", 32'(bin4), 32'h5);
        check("na1_ae",  32'(ae4),  32'h1);
        step(1'b1, 1'b1, 4'b0110);
        check("na2_bin", 32'(bin4), 32'h4);
        check("na2_ae",  32'(ae4),  32'h0);

        // Repeat with gaps, from a fresh reset; G is X while idle
        step(1'b0, 1'b0, 4'b0000);
        step(1'b1, 1'b1, 4'b0101);
        check("rep0_bin", 32'(bin4), 32'h6);
        check("rep0_ae",  32'(ae4),  32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 4'bxxxx);
            check($sformatf("gap_bin%0d", i), 32'(bin4), 32'h6);
            check($sformatf("gap_ov%0d", i),  32'(ov4),  32'h0);
            check($sformatf("gap_ae%0d", i),  32'(ae4),  32'h0);
        end
        step(1'b1, 1'b1, 4'b0101);
        check("rep1_bin", 32'(bin4), 32'h6);
        check("rep1_ov",  32'(ov4),  32'h1);
        check("rep1_ae",  32'(ae4),  32'h1);
        step(1'b1, 1'b0, 4'b0011);
        check("hold_ae",  32'(ae4),  32'h1);
        check("hold_ov",  32'(ov4),  32'h0);

        // Reset mid-stream with a valid word present
        step(1'b0, 1'b1, 4'b1111);
        check("mrst_bin", 32'(bin4), 32'h0);
        check("mrst_ov",  32'(ov4),  32'h0);
        check("mrst_ae",  32'(ae4),  32'h0);
        step(1'b1, 1'b1, 4'b1000);
        check("post_bin", 32'(bin4), 32'hF);
        check("post_ae",  32'(ae4),  32'h0);

        // Exhaustive conversion on both widths
        for (int i = 0; i < 256; i++) begin
            g8 = 8'(i);
            step(1'b1, 1'b1, 4'(i));
            check($sformatf("ex8_%0d", i), 32'(bin8), 32'(g2b8(8'(i))));
            if (i < 16)
                check($sformatf("ex4_%0d", i), 32'(bin4), 32'(g2b8(8'(i))));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
